// File: rtl/regfile_seq.sv
// regfile_seq: command sequencer that drives an 8x4 two-read/one-write
// register file. Each accepted command walks IDLE -> RD -> EX -> WB -> IDLE.
// Optional flag outputs (ZERO, CARRY) are built only when REGFILE_SEQ_FLAGS_EN
// is defined.
module regfile_seq #(
  parameter int NREG_AW = 3,
  parameter int DW      = 4
) (
  input  logic               CLK,
  input  logic               CLRN,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [1:0]         CMD_OP,
  input  logic [NREG_AW-1:0] CMD_DST,
  input  logic [NREG_AW-1:0] CMD_SRCP,
  input  logic [NREG_AW-1:0] CMD_SRCQ,
  input  logic [DW-1:0]      CMD_IMM,
  output logic [NREG_AW-1:0] RP,
  output logic [NREG_AW-1:0] RQ,
  input  logic [DW-1:0]      DATAP,
  input  logic [DW-1:0]      DATAQ,
  output logic [NREG_AW-1:0] WA,
  output logic               WR,
  output logic [DW-1:0]      LD_DATA,
  output logic               BUSY,
  output logic               DONE,
  output logic [DW-1:0]      RESULT
`ifdef REGFILE_SEQ_FLAGS_EN
  ,
  output logic               ZERO,
  output logic               CARRY
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  state_t               state_q, state_d;
  logic [1:0]           op_q;
  logic [NREG_AW-1:0]   dst_q, srcp_q, srcq_q, wa_q;
  logic [DW-1:0]        imm_q, opa_q, opb_q, res_q, result_q, res_d;
  logic                 done_q;
  logic                 accept;

`ifdef REGFILE_SEQ_FLAGS_EN
  logic [DW:0]          sum_w;
  logic                 carry_d, carry_ex_q, zero_q, carry_q;
`else
  logic [DW-1:0]        sum_w;
`endif

  assign accept = (state_q == S_IDLE) && CMD_VALID;

  // State register; reset aborts any command in flight immediately.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded handshake / write strobe.
  always_comb begin
    state_d   = state_q;
    CMD_READY = 1'b0;
    WR        = 1'b0;
    BUSY      = 1'b1;
    case (state_q)
      S_IDLE: begin
        CMD_READY = 1'b1;
        BUSY      = 1'b0;
        if (CMD_VALID) state_d = S_RD;
      end
      S_RD:    state_d = S_EX;
      S_EX:    state_d = S_WB;
      S_WB: begin
        WR      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result of the latched op on the captured operands.
  assign sum_w = opa_q + opb_q;
  always_comb begin
    res_d = opa_q;
    case (op_q)
      OP_LOAD: res_d = imm_q;
      OP_ADD:  res_d = sum_w[DW-1:0];
      OP_SUB:  res_d = opa_q - opb_q;
      default: res_d = opa_q;
    endcase
  end

`ifdef REGFILE_SEQ_FLAGS_EN
  // Carry-out for ADD, borrow for SUB, nothing for LOAD/MOV.
  always_comb begin
    carry_d = 1'b0;
    case (op_q)
      OP_ADD:  carry_d = sum_w[DW];
      OP_SUB:  carry_d = (opa_q < opb_q);
      default: carry_d = 1'b0;
    endcase
  end
`endif

  // Command latch, operand capture, execute and write-back registers.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      op_q     <= '0;
      dst_q    <= '0;
      srcp_q   <= '0;
      srcq_q   <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      wa_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef REGFILE_SEQ_FLAGS_EN
      carry_ex_q <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q   <= CMD_OP;
        dst_q  <= CMD_DST;
        srcp_q <= CMD_SRCP;
        srcq_q <= CMD_SRCQ;
        imm_q  <= CMD_IMM;
      end
      if (state_q == S_RD) begin
        opa_q <= DATAP;
        opb_q <= DATAQ;
      end
      // wa_q is separate from dst_q so WA holds while the next command latches.
      if (state_q == S_EX) begin
        res_q <= res_d;
        wa_q  <= dst_q;
`ifdef REGFILE_SEQ_FLAGS_EN
        carry_ex_q <= carry_d;
`endif
      end
      if (state_q == S_WB) begin
        result_q <= res_q;
        done_q   <= 1'b1;
`ifdef REGFILE_SEQ_FLAGS_EN
        zero_q  <= (res_q == '0);
        carry_q <= carry_ex_q;
`endif
      end
    end
  end

  assign RP      = srcp_q;
  assign RQ      = srcq_q;
  assign WA      = wa_q;
  assign LD_DATA = res_q;
  assign DONE    = done_q;
  assign RESULT  = result_q;
`ifdef REGFILE_SEQ_FLAGS_EN
  assign ZERO    = zero_q;
  assign CARRY   = carry_q;
`endif

endmodule
